// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states, flag bit positions.
package alu_share_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;
  localparam logic [1:0] OP_MIN = 2'b11;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_t;

endpackage

// File: rtl/alu_share_lib.sv
// Signed arithmetic library cells used by the shared unit.
module ADD #(parameter int W = 16) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = a + b;
endmodule

module SUB #(parameter int W = 16) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = a - b;
endmodule

module SCOMP #(parameter int W = 16) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                gt,
  output logic                lt,
  output logic                eq
);
  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;
endmodule

module SMUX2x1 #(parameter int W = 16) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: searches upward from ptr+1, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = IDW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one signed ADD/SUB/MAX/MIN unit between NREQ requesters.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      Clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [2*DATAWIDTH-1:0]    rsp_data,
  output logic [2:0]                rsp_flags
);

  localparam int RW = 2*DATAWIDTH;

  state_t                 state, state_nxt;
  logic [IDW-1:0]         ptr, gnt_idx, id_q;
  logic [NREQ-1:0]        gnt;
  logic                   any, accept_en, accept;
  logic [1:0]             op_sel, op_q;
  logic [DATAWIDTH-1:0]   a_sel, b_sel;
  logic signed [RW-1:0]   a_q, b_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // A new op may enter only when the unit is empty or the held result leaves this cycle.
  always_comb begin
    accept_en = (state == S_IDLE) || (state == S_HOLD && rsp_ready);
    req_ready = (rst && accept_en && any) ? gnt : '0;
    accept    = |req_ready;
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_sel = req_op[2*i +: 2];
        a_sel  = req_a[i*DATAWIDTH +: DATAWIDTH];
        b_sel  = req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_HOLD;
      S_HOLD:  if (rsp_ready) state_nxt = accept ? S_EXEC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= IDW'(NREQ-1);
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr  <= gnt_idx;
        id_q <= gnt_idx;
        op_q <= op_sel;
        a_q  <= {{DATAWIDTH{a_sel[DATAWIDTH-1]}}, a_sel};
        b_q  <= {{DATAWIDTH{b_sel[DATAWIDTH-1]}}, b_sel};
      end
    end
  end

  logic [RW-1:0] sum, diff, sel_res;
  logic [RW-1:0] alu_res;
  logic          gt, lt, eq, pick_a;

  ADD   #(.W(RW)) u_add (.a(a_q), .b(b_q), .y(sum));
  SUB   #(.W(RW)) u_sub (.a(a_q), .b(b_q), .y(diff));
  SCOMP #(.W(RW)) u_cmp (.a(a_q), .b(b_q), .gt(gt), .lt(lt), .eq(eq));

  // One mux serves both MAX and MIN; only the select condition differs.
  assign pick_a = (op_q == OP_MAX) ? gt : lt;
  SMUX2x1 #(.W(RW)) u_mux (.d0(b_q), .d1(a_q), .sel(pick_a), .y(sel_res));

  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      default: alu_res = sel_res;
    endcase
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else if (state == S_EXEC) begin
      rsp_valid          <= 1'b1;
      rsp_data           <= alu_res;
      rsp_id             <= id_q;
      rsp_flags[FLAG_GT] <= gt;
      rsp_flags[FLAG_LT] <= lt;
      rsp_flags[FLAG_EQ] <= eq;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_share_arb;

  logic        Clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;

  alu_share_arb #(.DATAWIDTH(8), .NREQ(4)) dut (
    .Clk(Clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  int top [4];
  int ta  [4];
  int tbv [4];

  // Model: pointer, an op in the unit, a response on the port.
  int          m_ptr;
  bit          m_exec, m_have;
  int          cap_id, cap_op, cap_a, cap_b;
  int          e_id;
  logic [18:0] e_res;
  int          m_g;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] ref_op(int op, int a, int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = (a > b) ? a : b;
      default: r = (a < b) ? a : b;
    endcase
    return {a > b, a < b, a == b, 16'(r)};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2] = 2'(top[i]);
      req_a[8*i +: 8]  = 8'(ta[i]);
      req_b[8*i +: 8]  = 8'(tbv[i]);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3; m_exec = 0; m_have = 0;
  endtask

  task automatic chk_cycle();
    bit can;
    logic [3:0] exp_rdy;
    drive();
    @(negedge Clk);
    can = !m_exec && (!m_have || rsp_ready);
    m_g = -1;
    for (int k = 1; k <= 4; k++)
      if (m_g < 0 && req_valid[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
    m_acc   = can && (m_g >= 0);
    exp_rdy = m_acc ? 4'(1 << m_g) : 4'b0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_have));
    if (m_have) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_data", 32'(rsp_data), 32'(e_res[15:0]));
      chk("rsp_flags", 32'(rsp_flags), 32'(e_res[18:16]));
    end
  endtask

  task automatic adv();
    if (m_exec) begin
      m_have = 1; m_exec = 0;
      e_id   = cap_id;
      e_res  = ref_op(cap_op, cap_a, cap_b);
    end else if (m_have && rsp_ready) begin
      m_have = 0;
    end
    if (m_acc) begin
      m_exec = 1; m_ptr = m_g;
      cap_id = m_g; cap_op = top[m_g]; cap_a = ta[m_g]; cap_b = tbv[m_g];
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_one(input int id, input int op, input int a, input int b,
                         input logic [15:0] xd, input logic [2:0] xf, input string tag);
    top[id] = op; ta[id] = a; tbv[id] = b;
    req_valid = 4'(1 << id);
    chk_cycle();
    chk({tag, "_accept"}, 32'(req_ready), 32'(1 << id));
    adv();
    req_valid = 4'b0;
    chk_cycle();
    adv();
    chk_cycle();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(xd));
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(xf));
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    adv();
  endtask

  int grants[$];
  int ids[$];
  logic [15:0] held_data;

  initial begin
    for (int i = 0; i < 4; i++) begin top[i] = 0; ta[i] = 0; tbv[i] = 0; end
    req_valid = 4'b0; rsp_ready = 1'b1; req_op = '0; req_a = '0; req_b = '0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 rst = 1'b1;
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);

    // Reset while req2 is in the unit.
    top[2] = 0; ta[2] = 7; tbv[2] = 9;
    req_valid = 4'b0100;
    chk_cycle();
    adv();
    req_valid = 4'b1111;
    rst = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge Clk);
    #1 rst = 1'b1;
    chk("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);

    // All requesters held: rotating grants two cycles apart.
    for (int i = 0; i < 4; i++) begin top[i] = i; ta[i] = 10 * i - 15; tbv[i] = 3 - i; end
    for (int c = 0; c < 10; c++) begin
      chk_cycle();
      for (int i = 0; i < 4; i++) if (req_ready[i]) grants.push_back(i);
      if (rsp_valid) ids.push_back(int'(rsp_id));
      adv();
    end
    chk("rr_grant_count", 32'(grants.size()), 32'd5);
    chk("rr_id_count", 32'(ids.size()), 32'd4);
    for (int k = 0; k < 5 && k < grants.size(); k++) chk("rr_grant_order", 32'(grants[k]), 32'(k % 4));
    for (int k = 0; k < 4 && k < ids.size(); k++) chk("rr_id_order", 32'(ids[k]), 32'(k));
    req_valid = 4'b0;
    repeat (3) begin chk_cycle(); adv(); end

    run_one(1, 0, 100, 100, 16'd200, 3'b001, "add");
    run_one(0, 1, -128, 127, 16'hFF01, 3'b010, "sub");
    run_one(3, 2, -5, 3, 16'd3, 3'b010, "max");
    run_one(3, 3, -5, 3, 16'hFFFB, 3'b010, "min");
    run_one(2, 2, 127, -128, 16'd127, 3'b100, "max_hi");

    // Back-pressure in HOLD, then same-cycle handoff to pending req2.
    top[0] = 0; ta[0] = 10; tbv[0] = 20;
    req_valid = 4'b0001;
    chk_cycle(); adv();
    req_valid = 4'b0; rsp_ready = 1'b0;
    chk_cycle(); adv();
    top[2] = 1; ta[2] = -50; tbv[2] = 60;
    req_valid = 4'b0100;
    held_data = 16'd30;
    for (int c = 0; c < 5; c++) begin
      chk_cycle();
      chk("hold_data", 32'(rsp_data), 32'(held_data));
      chk("hold_ready", 32'(req_ready), 32'd0);
      adv();
    end
    rsp_ready = 1'b1;
    chk_cycle();
    chk("handoff_ready", 32'(req_ready), 32'b0100);
    adv();
    req_valid = 4'b0;
    repeat (3) begin chk_cycle(); adv(); end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        top[i] = int'($urandom_range(0, 3));
        ta[i]  = int'($urandom_range(0, 255)) - 128;
        tbv[i] = int'($urandom_range(0, 255)) - 128;
      end
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      chk_cycle();
      adv();
    end
    req_valid = 4'b0; rsp_ready = 1'b1;
    repeat (4) begin chk_cycle(); adv(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
